// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [31:0] PC_INCR      = 32'h0000_0004;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;

  logic        Stall;
  logic        FlushIF;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic [31:0] Instruction_ID;
  logic [31:0] PC_ID;
  logic [31:0] PCPlus4_ID;
  logic        Valid_ID;
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport master (
    output Stall, FlushIF, BranchTaken, BranchTarget, IMemData,
    input  IMemAddr, Instruction_ID, PC_ID, PCPlus4_ID, Valid_ID,
    input  FetchCount, StallCount, FlushCount
  );

  modport slave (
    input  Stall, FlushIF, BranchTaken, BranchTarget, IMemData,
    output IMemAddr, Instruction_ID, PC_ID, PCPlus4_ID, Valid_ID,
    output FetchCount, StallCount, FlushCount
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr    <= BUBBLE_INSTR;
      pc       <= RESET_PC;
      pc_plus4 <= RESET_PC;
      valid    <= 1'b0;
    end else if (flush) begin
      // Bubble keeps the old PC fields so ID still sees a coherent address.
      instr <= BUBBLE_INSTR;
      valid <= 1'b0;
    end else if (load && !hold) begin
      instr    <= instr_in;
      pc       <= pc_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC sequencing FSM, IF/ID register and optional performance
// counters (compiled in with FETCH_PERF_CNT_EN).
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset_n,
  fetch_stage_if.slave bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_next_seq;
  logic         run;
  logic         fetch_load;
  logic [31:0]  instr_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_plus4_q;
  logic         valid_q;

  assign pc_next_seq = pc + PC_INCR;
  assign run         = (state == RUN);
  assign fetch_load  = run && !bus.FlushIF && !bus.Stall;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          pc    <= RESET_PC;
        end
        RUN: begin
          // A redirect wins over a stall so a taken branch is never lost.
          if (bus.BranchTaken)
            pc <= {bus.BranchTarget[31:2], 2'b00};
          else if (!bus.Stall)
            pc <= pc_next_seq;
        end
        default: begin
          state <= BOOT;
          pc    <= RESET_PC;
        end
      endcase
    end
  end

  assign bus.IMemAddr = pc;

  if_id_reg u_if_id_reg (
    .clk         (Clk),
    .rst_n       (Reset_n),
    .load        (run),
    .hold        (bus.Stall),
    .flush       (run && bus.FlushIF),
    .instr_in    (bus.IMemData),
    .pc_in       (pc),
    .pc_plus4_in (pc_next_seq),
    .instr       (instr_q),
    .pc          (pc_q),
    .pc_plus4    (pc_plus4_q),
    .valid       (valid_q)
  );

  assign bus.Instruction_ID = instr_q;
  assign bus.PC_ID          = pc_q;
  assign bus.PCPlus4_ID     = pc_plus4_q;
  assign bus.Valid_ID       = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (run) begin
      if (fetch_load)
        fetch_cnt <= sat_inc(fetch_cnt);
      if (bus.Stall)
        stall_cnt <= sat_inc(stall_cnt);
      if (bus.FlushIF)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.FetchCount = fetch_cnt;
  assign bus.StallCount = stall_cnt;
  assign bus.FlushCount = flush_cnt;
`else
  logic unused_fetch_load;
  assign unused_fetch_load = fetch_load;
  assign bus.FetchCount    = '0;
  assign bus.StallCount    = '0;
  assign bus.FlushCount    = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with a queue-based scoreboard.
module tb_fetch_stage;

  logic Clk;
  logic Reset_n;

  fetch_stage_if bus ();

  fetch_stage dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Instruction memory: word content is a fixed function of its address.
  assign bus.IMemData = 32'h2008_0001 ^ bus.IMemAddr;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    int          row;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic [31:0] pc4;
    logic [31:0] fc;
    logic [31:0] sc;
    logic [31:0] flc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   row_num  = 0;

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %08h expected %08h", name, row, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what must be visible after the edge.
  task automatic step(input logic rst_n, input logic stall, input logic flush,
                      input logic br, input logic [31:0] tgt,
                      input logic [31:0] addr, input logic valid,
                      input logic [31:0] instr, input logic [31:0] pc_id,
                      input logic [31:0] pc4, input logic [31:0] fc,
                      input logic [31:0] sc, input logic [31:0] flc);
    exp_t e;
    @(negedge Clk);
    Reset_n          = rst_n;
    bus.Stall        = stall;
    bus.FlushIF      = flush;
    bus.BranchTaken  = br;
    bus.BranchTarget = tgt;
    e.row   = row_num;
    e.addr  = addr;
    e.valid = valid;
    e.instr = instr;
    e.pc_id = pc_id;
    e.pc4   = pc4;
`ifdef FETCH_PERF_CNT_EN
    e.fc  = fc;
    e.sc  = sc;
    e.flc = flc;
`else
    e.fc  = 32'h0;
    e.sc  = 32'h0;
    e.flc = 32'h0;
`endif
    sb.push_back(e);
    row_num++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("imem_addr",  e.row, bus.IMemAddr,        e.addr);
        check("valid_id",   e.row, {31'b0, bus.Valid_ID}, {31'b0, e.valid});
        check("instr_id",   e.row, bus.Instruction_ID,  e.instr);
        check("pc_id",      e.row, bus.PC_ID,           e.pc_id);
        check("pcplus4_id", e.row, bus.PCPlus4_ID,      e.pc4);
        check("fetch_cnt",  e.row, bus.FetchCount,      e.fc);
        check("stall_cnt",  e.row, bus.StallCount,      e.sc);
        check("flush_cnt",  e.row, bus.FlushCount,      e.flc);
      end
    end
  end

  initial begin : driver
    Reset_n          = 1'b0;
    bus.Stall        = 1'b0;
    bus.FlushIF      = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 32'h0;

    //   rst stl fl br tgt            addr          v  instr          pc_id         pc4           fc  sc flc
    step(0, 0, 0, 0, 32'h0,         32'h0000_0000, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0000, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0004, 1, 32'h2008_0001, 32'h00,      32'h04,       1, 0, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0008, 1, 32'h2008_0005, 32'h04,      32'h08,       2, 0, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_000C, 1, 32'h2008_0009, 32'h08,      32'h0C,       3, 0, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0010, 1, 32'h2008_000D, 32'h0C,      32'h10,       4, 0, 0);
    // two-cycle stall at PC=0x10
    step(1, 1, 0, 0, 32'h0,         32'h0000_0010, 1, 32'h2008_000D, 32'h0C,      32'h10,       4, 1, 0);
    step(1, 1, 0, 0, 32'h0,         32'h0000_0010, 1, 32'h2008_000D, 32'h0C,      32'h10,       4, 2, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0014, 1, 32'h2008_0011, 32'h10,      32'h14,       5, 2, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0018, 1, 32'h2008_0015, 32'h14,      32'h18,       6, 2, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_001C, 1, 32'h2008_0019, 32'h18,      32'h1C,       7, 2, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0020, 1, 32'h2008_001D, 32'h1C,      32'h20,       8, 2, 0);
    // flushed branch to 0x40
    step(1, 0, 1, 1, 32'h40,        32'h0000_0040, 0, 32'h0,        32'h1C,       32'h20,       8, 2, 1);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0044, 1, 32'h2008_0041, 32'h40,      32'h44,       9, 2, 1);
    // unflushed branch keeps the delay-slot fetch
    step(1, 0, 0, 1, 32'h80,        32'h0000_0080, 1, 32'h2008_0045, 32'h44,      32'h48,      10, 2, 1);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0084, 1, 32'h2008_0081, 32'h80,      32'h84,      11, 2, 1);
    // stall + branch + flush, misaligned target
    step(1, 1, 1, 1, 32'h103,       32'h0000_0100, 0, 32'h0,        32'h80,       32'h84,      11, 3, 2);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0104, 1, 32'h2008_0101, 32'h100,     32'h104,     12, 3, 2);
    // wrap at the top of the address space
    step(1, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h2008_0105, 32'h104,     32'h108,     13, 3, 2);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0000, 1, 32'hDFF7_FFFD, 32'hFFFF_FFFC, 32'h0,     14, 3, 2);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0004, 1, 32'h2008_0001, 32'h00,      32'h04,      15, 3, 2);
    // reset asserted mid-stall at PC=0x30 with a pending redirect
    step(1, 0, 0, 1, 32'h30,        32'h0000_0030, 1, 32'h2008_0005, 32'h04,      32'h08,      16, 3, 2);
    step(1, 1, 0, 0, 32'h0,         32'h0000_0030, 1, 32'h2008_0005, 32'h04,      32'h08,      16, 4, 2);
    step(0, 1, 0, 1, 32'h80,        32'h0000_0000, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
    // BOOT ignores every control input
    step(1, 1, 1, 1, 32'h80,        32'h0000_0000, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0004, 1, 32'h2008_0001, 32'h00,      32'h04,       1, 0, 0);
    // flush wins over stall without a branch
    step(1, 1, 1, 0, 32'h0,         32'h0000_0004, 0, 32'h0,        32'h00,       32'h04,       1, 1, 1);
    step(1, 0, 0, 0, 32'h0,         32'h0000_0008, 1, 32'h2008_0005, 32'h04,      32'h08,       2, 1, 1);

    @(negedge Clk);
    bus.Stall = 1'b0;
    @(negedge Clk);
    check("scoreboard_drained", -1, sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
